// File: rtl/mining_result_framer_if.sv
// Byte-stream link between the result framer and its byte sink (UART TX or similar).
//
// Handshake: the master raises tx_valid with tx_data. Once tx_valid is high, tx_data and
// tx_valid stay unchanged until the slave has tx_ready high on a rising edge. That edge is
// the transfer. tx_valid never drops without a transfer. tx_ready is ignored while
// tx_valid is low.
interface mining_result_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/mining_result_framer.sv
// Mining result framer.
//
// Watches the miner's busy flag. When a run ends (busy falls), it snapshots found, nonce and
// hash, then streams one frame over the tx link:
//   SYNC_BYTE, STATUS (01 found / 00 exhausted), nonce MSB first, HASH_BYTES hash bytes MSB first.
// If a run ends while a frame is still in flight, that result is dropped and the sticky
// overrun flag is set.
//
// Optional feature macro: RESULT_CHECKSUM_EN. When defined, the frame gets one more byte:
// the XOR of every byte after SYNC.
module mining_result_framer #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         HASH_BYTES = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          miner_busy,
    input  logic                          miner_found,
    input  logic [31:0]                   miner_nonce,
    input  logic [255:0]                  miner_hash,
    mining_result_framer_if.master        tx,
    output logic                          frame_busy,
    output logic                          overrun,
    output logic [15:0]                   frames_sent
);

`ifdef RESULT_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    localparam int         FRAME_LEN = 6 + HASH_BYTES + CSUM_BYTES;
    localparam logic [5:0] LAST_IDX  = 6'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t         state;
    logic           busy_q;
    logic           snap_found;
    logic [31:0]    snap_nonce;
    logic [255:0]   snap_hash;
    logic [5:0]     idx;
    logic [7:0]     data_q;
    logic           valid_q;
    logic [7:0]     next_byte;
    logic           run_end;
    logic           accept;
`ifdef RESULT_CHECKSUM_EN
    logic [7:0]     csum;
`endif

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;

    // A run ends on the cycle busy is seen falling; it cannot coincide with busy rising.
    assign run_end = busy_q && !miner_busy;
    assign accept  = valid_q && tx.tx_ready;

    // Byte i of the frame, built from the snapshot (the checksum byte is handled separately).
    function automatic logic [7:0] frame_byte(input logic [5:0] i);
        logic [7:0] b;
        logic [1:0] nsel;
        logic [4:0] hsel;
        b    = 8'h00;
        nsel = 2'(6'd5 - i);
        hsel = 5'(6'd37 - i);
        if (i == 6'd0) begin
            b = SYNC_BYTE;
        end else if (i == 6'd1) begin
            b = snap_found ? 8'h01 : 8'h00;
        end else if (i < 6'd6) begin
            b = snap_nonce[{nsel, 3'b000} +: 8];
        end else begin
            b = snap_hash[{hsel, 3'b000} +: 8];
        end
        return b;
    endfunction

    // Byte to present after the current one is accepted.
    always_comb begin
        next_byte = frame_byte(idx + 6'd1);
`ifdef RESULT_CHECKSUM_EN
        if ((idx + 6'd1) == LAST_IDX) begin
            next_byte = csum ^ data_q;
        end
`endif
    end

    // Framer FSM: snapshot on run end, then step through the frame one accepted byte at a time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            snap_found  <= 1'b0;
            snap_nonce  <= 32'h0;
            snap_hash   <= 256'h0;
            idx         <= 6'd0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_busy  <= 1'b0;
            overrun     <= 1'b0;
            frames_sent <= 16'h0000;
`ifdef RESULT_CHECKSUM_EN
            csum        <= 8'h00;
`endif
        end else begin
            busy_q <= miner_busy;
            case (state)
                IDLE: begin
                    if (run_end) begin
                        snap_found <= miner_found;
                        snap_nonce <= miner_nonce;
                        snap_hash  <= miner_hash;
                        idx        <= 6'd0;
                        data_q     <= SYNC_BYTE;
                        valid_q    <= 1'b1;
                        frame_busy <= 1'b1;
                        state      <= SEND;
`ifdef RESULT_CHECKSUM_EN
                        csum       <= 8'h00;
`endif
                    end
                end
                SEND: begin
                    // Includes the cycle the last byte goes out: that result is still lost.
                    if (run_end) begin
                        overrun <= 1'b1;
                    end
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            valid_q     <= 1'b0;
                            data_q      <= 8'h00;
                            frame_busy  <= 1'b0;
                            frames_sent <= frames_sent + 16'd1;
                            idx         <= 6'd0;
                            state       <= IDLE;
                        end else begin
                            idx    <= idx + 6'd1;
                            data_q <= next_byte;
`ifdef RESULT_CHECKSUM_EN
                            if (idx != 6'd0) begin
                                csum <= csum ^ data_q;
                            end
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mining_result_framer.sv
// Directed bench for mining_result_framer: a default build (32 hash bytes) and a
// zero-hash-byte instance, checked against hand-built expected byte queues.
module tb_mining_result_framer;

    logic         clk;
    logic         rst_n;
    logic         busy;
    logic         busy0;
    logic         found;
    logic [31:0]  nonce;
    logic [255:0] hash;
    logic         frame_busy, overrun;
    logic [15:0]  frames_sent;
    logic         frame_busy0, overrun0;
    logic [15:0]  frames_sent0;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_frames = 0;
    logic [7:0] exp_q[$];

    localparam logic [255:0] HASH_A =
        256'hDEAD0102_03040506_0708090A_0B0C0D0E_0F101112_13141516_17181920_2122BEEF;

    mining_result_framer_if tx ();
    mining_result_framer_if tx0 ();

    mining_result_framer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .miner_busy  (busy),
        .miner_found (found),
        .miner_nonce (nonce),
        .miner_hash  (hash),
        .tx          (tx.master),
        .frame_busy  (frame_busy),
        .overrun     (overrun),
        .frames_sent (frames_sent)
    );

    mining_result_framer #(.HASH_BYTES(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .miner_busy  (busy0),
        .miner_found (found),
        .miner_nonce (nonce),
        .miner_hash  (hash),
        .tx          (tx0.master),
        .frame_busy  (frame_busy0),
        .overrun     (overrun0),
        .frames_sent (frames_sent0)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected frame: SYNC, STATUS, nonce MSB first, nh hash bytes MSB first, optional XOR.
    task automatic build_exp(input bit f, input logic [31:0] n, input logic [255:0] h, input int nh);
        logic [7:0]   x;
        logic [255:0] hs;
        logic [31:0]  ns;
        exp_q.push_back(8'hA5);
        exp_q.push_back(f ? 8'h01 : 8'h00);
        x  = f ? 8'h01 : 8'h00;
        ns = n;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(ns[31:24]);
            x  = x ^ ns[31:24];
            ns = ns << 8;
        end
        hs = h;
        for (int k = 0; k < nh; k++) begin
            exp_q.push_back(hs[255:248]);
            x  = x ^ hs[255:248];
            hs = hs << 8;
        end
`ifdef RESULT_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Drive a run end (busy 1 -> 0) and check the SYNC byte appears one cycle later.
    task automatic run_end(input bit sel, input bit f, input logic [31:0] n, input logic [255:0] h,
                           input string tag);
        @(negedge clk);
        if (sel) busy0 = 1'b1; else busy = 1'b1;
        @(negedge clk);
        found = f;
        nonce = n;
        hash  = h;
        if (sel) busy0 = 1'b0; else busy = 1'b0;
        @(negedge clk);
        check({tag, " first valid"}, 32'(sel ? tx0.tx_valid : tx.tx_valid), 32'd1);
        check({tag, " first busy"}, 32'(sel ? frame_busy0 : frame_busy), 32'd1);
    endtask

    // Accept n bytes, comparing each with the expected queue. Optional backpressure and an
    // optional second run end once pulse_at bytes have been accepted.
    task automatic drain(input bit sel, input int n, input bit bp, input int pulse_at,
                         input string tag);
        int         got = 0;
        int         cyc = 0;
        int         pstep = 0;
        bit         stalled = 0;
        logic [7:0] held = 8'h00;
        logic [7:0] d;
        logic [7:0] e;
        logic       v;
        logic       r;
        while (got < n && cyc < 600) begin
            if (pulse_at >= 0 && pstep == 1) begin
                busy  = 1'b0;
                found = 1'b0;
                nonce = 32'hCAFEF00D;
                hash  = ~HASH_A;
                pstep = 2;
            end
            if (pulse_at >= 0 && pstep == 0 && got == pulse_at) begin
                busy  = 1'b1;
                pstep = 1;
            end
            r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sel) tx0.tx_ready = r; else tx.tx_ready = r;
            v = sel ? tx0.tx_valid : tx.tx_valid;
            d = sel ? tx0.tx_data : tx.tx_data;
            if (stalled) begin
                check({tag, " stall valid"}, 32'(v), 32'd1);
                check({tag, " stall data"}, 32'(d), 32'(held));
            end else if (!bp) begin
                check({tag, " valid"}, 32'(v), 32'd1);
            end
            if (v && r) begin
                e = exp_q.pop_front();
                check({tag, " byte"}, 32'(d), 32'(e));
                got++;
                stalled = 0;
            end else if (v) begin
                stalled = 1;
                held    = d;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, " byte count"}, 32'(got), 32'(n));
        tx.tx_ready  = 1'b0;
        tx0.tx_ready = 1'b0;
    endtask

    // After a full frame: link idle, frame_busy low, frame counted.
    task automatic post_frame(input string tag);
        check({tag, " end valid"}, 32'(tx.tx_valid), 32'd0);
        check({tag, " end frame_busy"}, 32'(frame_busy), 32'd0);
        check({tag, " frames_sent"}, 32'(frames_sent), 32'(exp_frames));
        check({tag, " queue empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int frame_len;
        bit saw_valid;
        frame_len = 38;
`ifdef RESULT_CHECKSUM_EN
        frame_len = 39;
`endif
        rst_n        = 1'b0;
        busy         = 1'b0;
        busy0        = 1'b0;
        found        = 1'b0;
        nonce        = 32'h0;
        hash         = 256'h0;
        tx.tx_ready  = 1'b0;
        tx0.tx_ready = 1'b0;

        // Reset values
        #2;
        check("rst tx_valid", 32'(tx.tx_valid), 32'd0);
        check("rst tx_data", 32'(tx.tx_data), 32'd0);
        check("rst frame_busy", 32'(frame_busy), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst frames_sent", 32'(frames_sent), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // tx_ready while idle is ignored
        tx.tx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("idle ready valid", 32'(tx.tx_valid), 32'd0);
        check("idle ready frames", 32'(frames_sent), 32'd0);
        tx.tx_ready = 1'b0;

        // Found run, tx_ready held high
        build_exp(1'b1, 32'h12345678, HASH_A, 32);
        check("found first exp byte", 32'(exp_q[6]), 32'hDE);
        run_end(1'b0, 1'b1, 32'h12345678, HASH_A, "found");
        drain(1'b0, frame_len, 1'b0, -1, "found");
        exp_frames++;
        post_frame("found");

        // Exhausted run
        build_exp(1'b0, 32'hFFFFFFFF, HASH_A, 32);
        check("exhausted exp status", 32'(exp_q[1]), 32'h00);
        run_end(1'b0, 1'b0, 32'hFFFFFFFF, HASH_A, "exhausted");
        drain(1'b0, frame_len, 1'b0, -1, "exhausted");
        exp_frames++;
        post_frame("exhausted");

        // Backpressure: same frame as the found run
        build_exp(1'b1, 32'h12345678, HASH_A, 32);
        run_end(1'b0, 1'b1, 32'h12345678, HASH_A, "backpressure");
        drain(1'b0, frame_len, 1'b1, -1, "backpressure");
        exp_frames++;
        post_frame("backpressure");

        // Overrun: another run end at byte 10 with new data that must not leak in
        build_exp(1'b1, 32'h12345678, HASH_A, 32);
        run_end(1'b0, 1'b1, 32'h12345678, HASH_A, "overrun");
        drain(1'b0, frame_len, 1'b0, 10, "overrun");
        exp_frames++;
        post_frame("overrun");
        check("overrun flag", 32'(overrun), 32'd1);
        tx.tx_ready = 1'b1;
        saw_valid   = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (tx.tx_valid) saw_valid = 1'b1;
        end
        tx.tx_ready = 1'b0;
        check("overrun no second frame", 32'(saw_valid), 32'd0);
        check("overrun frames held", 32'(frames_sent), 32'(exp_frames));
        check("overrun sticky", 32'(overrun), 32'd1);

        // Reset in the middle of a frame
        build_exp(1'b1, 32'hA1B2C3D4, HASH_A, 32);
        run_end(1'b0, 1'b1, 32'hA1B2C3D4, HASH_A, "midreset");
        drain(1'b0, 5, 1'b0, -1, "midreset");
        rst_n = 1'b0;
        #1;
        check("midreset tx_valid", 32'(tx.tx_valid), 32'd0);
        check("midreset tx_data", 32'(tx.tx_data), 32'd0);
        check("midreset frame_busy", 32'(frame_busy), 32'd0);
        check("midreset frames_sent", 32'(frames_sent), 32'd0);
        check("midreset overrun", 32'(overrun), 32'd0);
        exp_q.delete();
        exp_frames = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Full frame from SYNC after the reset
        build_exp(1'b1, 32'hA1B2C3D4, HASH_A, 32);
        run_end(1'b0, 1'b1, 32'hA1B2C3D4, HASH_A, "after reset");
        drain(1'b0, frame_len, 1'b0, -1, "after reset");
        exp_frames++;
        post_frame("after reset");

        // Zero hash bytes: frame ends after nonce[7:0] (plus checksum 05 if enabled)
        build_exp(1'b1, 32'h01020304, HASH_A, 0);
`ifdef RESULT_CHECKSUM_EN
        check("nohash exp checksum", 32'(exp_q[6]), 32'h05);
        run_end(1'b1, 1'b1, 32'h01020304, HASH_A, "nohash");
        drain(1'b1, 7, 1'b0, -1, "nohash");
`else
        run_end(1'b1, 1'b1, 32'h01020304, HASH_A, "nohash");
        drain(1'b1, 6, 1'b0, -1, "nohash");
`endif
        check("nohash end valid", 32'(tx0.tx_valid), 32'd0);
        check("nohash frame_busy", 32'(frame_busy0), 32'd0);
        check("nohash frames_sent", 32'(frames_sent0), 32'd1);
        check("nohash overrun", 32'(overrun0), 32'd0);
        check("nohash queue empty", 32'(exp_q.size()), 32'd0);
        check("main unaffected", 32'(frames_sent), 32'(exp_frames));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
